ram_bank_sync: RTL

- Parametrised successor to the team's 4x1-bit clock-gated RAM.
- Provides 2**AW words of WIDTH bits on a single free-running clock, with write enable, a registered read port and a hardware clear sequencer that sweeps every word to zero.
- Sits behind the board switch and LED glue.
- Replaces per-word gated clocks with enable-based flops.

---
 rtl/ram_bank_sync.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ram_bank_sync.sv
// ram_bank_sync: 2**AW x WIDTH flop-based RAM on a single free-running clock.
// Writes are enable-qualified (no gated clocks), reads are registered with
// write-first behaviour, and a clear sequencer sweeps every word to zero
// while holding busy high for exactly DEPTH cycles.
module ram_bank_sync #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] d,
    input  logic             we,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             clk_led,
    output logic             busy_led
);

    localparam int DEPTH = 1 << AW;
    // Terminal sweep index; ptr is AW bits so it can never leave the array.
    localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [AW-1:0]      ptr_r;
    logic [AW-1:0]      ptr_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic [WIDTH-1:0]   q_r;

    logic               wr_en_s;     // user write lands this edge
    logic               clr_en_s;    // sweep write of zero lands this edge
    logic               rd_en_s;     // read port updates this edge
    logic [AW-1:0]      wr_idx_s;
    logic [WIDTH-1:0]   wr_data_s;
    logic [WIDTH-1:0]   rd_data_s;
    logic [DEPTH-1:0]   word_we_s;

    logic [WIDTH-1:0]   mem_r [DEPTH];

    // Control state register: sweep FSM, pointer and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Next-state logic: clr has priority over we in IDLE; CLEAR ignores both
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        busy_nxt_s  = busy_r;
        wr_en_s     = 1'b0;
        clr_en_s    = 1'b0;
        rd_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rd_en_s = 1'b1;
                if (clr) begin
                    state_nxt_s = ST_CLEAR;
                    ptr_nxt_s   = {AW{1'b0}};
                    busy_nxt_s  = 1'b1;
                end else if (we) begin
                    wr_en_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                clr_en_s  = 1'b1;
                ptr_nxt_s = ptr_r + {{(AW-1){1'b0}}, 1'b1};
                if (ptr_r == PTR_LAST) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_CLEAR;
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = {AW{1'b0}};
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Write port select: sweep pointer and zero data during CLEAR, else user port
    always_comb begin
        wr_idx_s  = addr;
        wr_data_s = d;
        word_we_s = {DEPTH{1'b0}};
        if (clr_en_s) begin
            wr_idx_s  = ptr_r;
            wr_data_s = {WIDTH{1'b0}};
        end else begin
            wr_idx_s  = addr;
            wr_data_s = d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((wr_en_s || clr_en_s) && (wr_idx_s == AW'(i))) begin
                word_we_s[i] = 1'b1;
            end else begin
                word_we_s[i] = 1'b0;
            end
        end
    end

    // Storage array: each word only changes when its decoded enable is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_we_s[i]) begin
                    mem_r[i] <= wr_data_s;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Read data select: a same-edge write bypasses the array (write-first)
    always_comb begin
        if (wr_en_s) begin
            rd_data_s = d;
        end else begin
            rd_data_s = mem_r[addr];
        end
    end

    // Registered read port: updates on IDLE edges, holds during the sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (rd_en_s) begin
            q_r <= rd_data_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q        = q_r;
    assign busy     = busy_r;
    assign clk_led  = clk;
    assign busy_led = busy_r;

endmodule
